// File: rtl/symbol_upsampler_pkg.sv
// symbol_upsampler_pkg: rate and phase constants shared by the Tx upsampler, Tx FIR and Rx downsampler
package symbol_upsampler_pkg;
  localparam int NB_DATA = 8;
  localparam int OS_FACTOR = 4;
  localparam int NB_PHASE = $clog2(OS_FACTOR);
  localparam int FIFO_DEPTH = 4;
  localparam int NB_ADDR = $clog2(FIFO_DEPTH);
  localparam logic [NB_PHASE-1:0] SYM_PHASE = '0;
endpackage

// File: rtl/symbol_upsampler_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy-count full/empty
module sync_fifo #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 2
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               push,
  input  logic               pop,
  input  logic [NB_DATA-1:0] wr_data,
  output logic [NB_DATA-1:0] rd_data,
  output logic               full,
  output logic               empty,
  output logic [NB_ADDR:0]   level
);
  logic [NB_DATA-1:0] mem [2**NB_ADDR];
  logic [NB_ADDR-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    full = level == (NB_ADDR+1)'(2**NB_ADDR);
    empty = level == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    rd_data = mem[rd_ptr];
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + NB_ADDR'(do_push);
      rd_ptr <= rd_ptr + NB_ADDR'(do_pop);
      level <= level + (NB_ADDR+1)'(do_push) - (NB_ADDR+1)'(do_pop);
    end
  end
endmodule

// File: rtl/symbol_upsampler.sv
// symbol_upsampler: zero-stuffs queued symbols to OS_FACTOR samples/symbol for the Tx FIR
module symbol_upsampler
  import symbol_upsampler_pkg::*;
#(
  parameter int NB_DATA = symbol_upsampler_pkg::NB_DATA,
  parameter int OS_FACTOR = symbol_upsampler_pkg::OS_FACTOR,
  parameter int NB_PHASE = symbol_upsampler_pkg::NB_PHASE,
  parameter int FIFO_DEPTH = symbol_upsampler_pkg::FIFO_DEPTH,
  parameter int NB_ADDR = symbol_upsampler_pkg::NB_ADDR
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic [NB_DATA-1:0]  i_sym_data,
  input  logic                i_sym_valid,
  output logic                o_sym_ready,
  input  logic                i_clr_underrun,
  output logic [NB_DATA-1:0]  o_data,
  output logic                o_data_valid,
  output logic [NB_PHASE-1:0] o_phase,
  output logic                o_sym_tick,
  output logic                o_underrun,
  output logic [NB_ADDR:0]    o_fifo_level
);
  if (OS_FACTOR != 2**NB_PHASE || FIFO_DEPTH != 2**NB_ADDR) begin : g_bad_params
    $error("symbol_upsampler: OS_FACTOR/FIFO_DEPTH must equal 2**NB_PHASE/2**NB_ADDR");
  end
  logic [NB_PHASE-1:0] phase_cnt;
  logic [NB_DATA-1:0] head;
  logic full, empty, slot, push, pop;
  always_comb begin
    slot = i_enable && phase_cnt == NB_PHASE'(SYM_PHASE);
    o_sym_ready = !full;
    push = i_sym_valid && o_sym_ready;
    pop = slot && !empty;
  end
  sync_fifo #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) u_fifo (
    .clk(clk), .i_rst(i_rst), .push(push), .pop(pop), .wr_data(i_sym_data),
    .rd_data(head), .full(full), .empty(empty), .level(o_fifo_level)
  );
  always_ff @(posedge clk) begin
    if (i_rst) begin
      phase_cnt <= '0;
      o_data <= '0;
      o_data_valid <= 1'b0;
      o_phase <= '0;
      o_sym_tick <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      if (i_enable) begin
        phase_cnt <= phase_cnt == NB_PHASE'(OS_FACTOR-1) ? '0 : phase_cnt + NB_PHASE'(1);
        o_data <= pop ? head : '0;
        o_phase <= phase_cnt;
      end
      o_data_valid <= i_enable;
      o_sym_tick <= slot;
      // a set in the same cycle as a clear must win
      o_underrun <= (slot && empty) ? 1'b1 : i_clr_underrun ? 1'b0 : o_underrun;
    end
  end
endmodule

// File: tb/tb_symbol_upsampler.sv
// tb_symbol_upsampler: table-driven directed check of symbol_upsampler
module tb_symbol_upsampler;
  logic clk = 1'b0, i_rst = 1'b0, i_enable = 1'b0, i_sym_valid = 1'b0, i_clr_underrun = 1'b0;
  logic [7:0] i_sym_data = '0;
  logic o_sym_ready, o_data_valid, o_sym_tick, o_underrun;
  logic [7:0] o_data;
  logic [1:0] o_phase;
  logic [2:0] o_fifo_level;
  int checks = 0, errors = 0;

  symbol_upsampler dut (
    .clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_sym_data(i_sym_data),
    .i_sym_valid(i_sym_valid), .o_sym_ready(o_sym_ready), .i_clr_underrun(i_clr_underrun),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_phase(o_phase), .o_sym_tick(o_sym_tick),
    .o_underrun(o_underrun), .o_fifo_level(o_fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, en, vld, clr;
    logic [7:0] d, e_data;
    logic e_valid, e_tick, e_und, e_ready;
    logic [1:0] e_phase;
    logic [2:0] e_level;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int rst, en, vld, d, clr, ed, ev, ep, et, eu, el, er);
    vec_t v;
    v.rst = 1'(rst); v.en = 1'(en); v.vld = 1'(vld); v.d = 8'(d); v.clr = 1'(clr);
    v.e_data = 8'(ed); v.e_valid = 1'(ev); v.e_phase = 2'(ep); v.e_tick = 1'(et);
    v.e_und = 1'(eu); v.e_level = 3'(el); v.e_ready = 1'(er);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic step(input logic rst, en, vld, input logic [7:0] d, input logic clr);
    i_rst = rst; i_enable = en; i_sym_valid = vld; i_sym_data = d; i_clr_underrun = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    chk("data", idx, o_data, v.e_data);
    chk("valid", idx, 8'(o_data_valid), 8'(v.e_valid));
    chk("phase", idx, 8'(o_phase), 8'(v.e_phase));
    chk("tick", idx, 8'(o_sym_tick), 8'(v.e_tick));
    chk("underrun", idx, 8'(o_underrun), 8'(v.e_und));
    chk("level", idx, 8'(o_fifo_level), 8'(v.e_level));
    chk("ready", idx, 8'(o_sym_ready), 8'(v.e_ready));
  endtask

  initial begin
    int n;
    //                rst en vld  d  clr  data vld ph tk und lvl rdy
    tbl.push_back(mk(1, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1,  3, 0,   0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, -3, 0,   0, 0, 0, 0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 1,  1, 0,   0, 0, 0, 0, 0, 3, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   3, 1, 0, 1, 0, 2, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 1, 0, 0, 2, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 2, 0, 0, 2, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 3, 0, 0, 2, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,  -3, 1, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 2, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 3, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   1, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 2, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 3, 0, 0, 0, 1));
    // empty symbol slot: underrun, then clear, then set+clear together
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0,  0, 1,   0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 2, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 3, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0,  0, 1,   0, 1, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0,  0, 1,   0, 0, 0, 0, 0, 0, 1));
    // enable toggling with 5,7 queued
    tbl.push_back(mk(1, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1,  5, 0,   0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1,  7, 0,   0, 0, 0, 0, 0, 2, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   5, 1, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0,  0, 0,   5, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0,  0, 0,   0, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 2, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0,  0, 0,   0, 0, 2, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 3, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0,  0, 0,   0, 0, 3, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   7, 1, 0, 1, 0, 0, 1));
    // fill to full with no enable; fifth symbol held off
    tbl.push_back(mk(1, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 10, 0,   0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 11, 0,   0, 0, 0, 0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 1, 12, 0,   0, 0, 0, 0, 0, 3, 1));
    tbl.push_back(mk(0, 0, 1, 13, 0,   0, 0, 0, 0, 0, 4, 0));
    tbl.push_back(mk(0, 0, 1, 14, 0,   0, 0, 0, 0, 0, 4, 0));
    tbl.push_back(mk(0, 1, 1, 14, 0,  10, 1, 0, 1, 0, 3, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 1, 0, 0, 3, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 2, 0, 0, 3, 1));
    // reset mid-stream at level 3, phase 2; the push under reset is dropped
    tbl.push_back(mk(1, 1, 1,  9, 0,   0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1,  9, 0,   0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, -8, 0,   9, 1, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 2, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,   0, 1, 3, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0,  -8, 1, 0, 1, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].vld, tbl[i].d, tbl[i].clr);
      chk_all(i, tbl[i]);
    end

    // push into an empty FIFO on a symbol slot: underrun now, symbol one period later
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 8'd6, 0);
    chk("push_on_underrun_data", 100, o_data, 8'd0);
    chk("push_on_underrun_flag", 100, 8'(o_underrun), 8'd1);
    chk("push_on_underrun_level", 100, 8'(o_fifo_level), 8'd1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0, 0);
      n++;
      if (o_sym_tick) break;
    end
    chk("late_sym_cycles", 101, 8'(n), 8'd4);
    chk("late_sym_data", 101, o_data, 8'd6);
    chk("late_sym_level", 101, 8'(o_fifo_level), 8'd0);

    // sticky flag survives disabled cycles until cleared
    step(0, 0, 0, 0, 0);
    chk("sticky_hold", 102, 8'(o_underrun), 8'd1);
    step(0, 0, 0, 0, 1);
    chk("sticky_clear", 103, 8'(o_underrun), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
